// File: rtl/norm_round_pack_if.sv
// Valid/ready bundle between a raw-magnitude producer and the normalize/round/pack stage.
// The slave modport is the pipeline's view; master is the producer/consumer side.
interface norm_round_pack_if #(
  parameter int DATA_W = 8,
  parameter int MANT_W = 4
);
  localparam int EXP_W = $clog2(DATA_W) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_vector;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_inexact;

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_inexact
  );

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_inexact
  );
endinterface

// File: rtl/norm_round_pack.sv
// Two-stage valid/ready pipeline: normalize a raw magnitude, then round-to-nearest-even
// to MANT_W bits and pack mantissa, exponent, zero and inexact flags.
module normalization_module #(
  parameter int DATA_W = 8,
  parameter int LZC_W  = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] in_vector,
  output logic [DATA_W-1:0] norm,
  output logic [LZC_W-1:0]  lzc
);
  // Ascending scan: the highest set bit is the last one to write lzc.
  always_comb begin
    lzc = LZC_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (in_vector[i]) lzc = LZC_W'(DATA_W - 1 - i);
    end
    norm = in_vector << lzc;
  end
endmodule

module norm_round_pack #(
  parameter int DATA_W = 8,
  parameter int MANT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  norm_round_pack_if.slave  bus
);
  localparam int EXP_W = $clog2(DATA_W) + 1;
  localparam int RND_W = 1 + EXP_W + MANT_W;

  // Returns {inexact, exp, mant}; a carry out of the mantissa renormalizes to 1.00..0.
  function automatic logic [RND_W-1:0] round_rne(
    input logic [DATA_W-1:0] norm,
    input logic [EXP_W-1:0]  exp_in
  );
    logic [MANT_W-1:0] keep;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp_o;
    logic              guard;
    logic              sticky;
    logic              round_up;
    keep   = norm[DATA_W-1 -: MANT_W];
    guard  = norm[DATA_W-1-MANT_W];
    sticky = 1'b0;
    for (int i = 0; i < DATA_W - 1 - MANT_W; i++) sticky = sticky | norm[i];
    round_up = guard && (sticky || keep[0]);
    if (round_up && (&keep)) begin
      mant  = {1'b1, {(MANT_W-1){1'b0}}};
      exp_o = exp_in + EXP_W'(1);
    end else begin
      mant  = keep + MANT_W'(round_up);
      exp_o = exp_in;
    end
    return {guard | sticky, exp_o, mant};
  endfunction

  logic [DATA_W-1:0] norm_w;
  logic [EXP_W-1:0]  lzc_w;

  normalization_module #(.DATA_W(DATA_W), .LZC_W(EXP_W)) u_norm (
    .in_vector (bus.in_vector),
    .norm      (norm_w),
    .lzc       (lzc_w)
  );

  logic              s1_adv, s2_adv, ld_p1, ld_p2;
  logic              vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [DATA_W-1:0] norm_p1_d, norm_p1_q;
  logic [EXP_W-1:0]  exp_p1_d, exp_p1_q;
  logic              zero_p1_d, zero_p1_q;
  logic [MANT_W-1:0] mant_p2_d, mant_p2_q;
  logic [EXP_W-1:0]  exp_p2_d, exp_p2_q;
  logic              zero_p2_d, zero_p2_q;
  logic              inexact_p2_d, inexact_p2_q;
  logic [RND_W-1:0]  rnd;

  always_comb begin
    s2_adv   = !vld_p2_q || bus.out_ready;
    s1_adv   = !vld_p1_q || s2_adv;
    ld_p1    = s1_adv && bus.in_valid;
    ld_p2    = s2_adv && vld_p1_q;
    vld_p1_d = s1_adv ? bus.in_valid : vld_p1_q;
    vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;

    // Stage 1: capture normalized word and leading-one index.
    norm_p1_d = norm_p1_q;
    exp_p1_d  = exp_p1_q;
    zero_p1_d = zero_p1_q;
    if (ld_p1) begin
      norm_p1_d = norm_w;
      zero_p1_d = (bus.in_vector == '0);
      exp_p1_d  = zero_p1_d ? '0 : EXP_W'(DATA_W - 1) - lzc_w;
    end

    // Stage 2: round and pack.
    rnd          = round_rne(norm_p1_q, exp_p1_q);
    mant_p2_d    = mant_p2_q;
    exp_p2_d     = exp_p2_q;
    zero_p2_d    = zero_p2_q;
    inexact_p2_d = inexact_p2_q;
    if (ld_p2) begin
      zero_p2_d    = zero_p1_q;
      mant_p2_d    = zero_p1_q ? '0 : rnd[MANT_W-1:0];
      exp_p2_d     = zero_p1_q ? '0 : rnd[MANT_W +: EXP_W];
      inexact_p2_d = zero_p1_q ? 1'b0 : rnd[RND_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      mant_p2_q    <= '0;
      exp_p2_q     <= '0;
      zero_p2_q    <= 1'b0;
      inexact_p2_q <= 1'b0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      mant_p2_q    <= mant_p2_d;
      exp_p2_q     <= exp_p2_d;
      zero_p2_q    <= zero_p2_d;
      inexact_p2_q <= inexact_p2_d;
    end
  end

  // Stage-1 payload is only meaningful under vld_p1_q, so it carries no reset.
  always_ff @(posedge clk) begin
    norm_p1_q <= norm_p1_d;
    exp_p1_q  <= exp_p1_d;
    zero_p1_q <= zero_p1_d;
  end

  assign bus.in_ready    = s1_adv;
  assign bus.out_valid   = vld_p2_q;
  assign bus.out_mant    = mant_p2_q;
  assign bus.out_exp     = exp_p2_q;
  assign bus.out_zero    = zero_p2_q;
  assign bus.out_inexact = inexact_p2_q;
endmodule
